// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared states, mode encodings and default timing constants for the valve sequencer
package irrigation_pkg;

    typedef enum logic [1:0] {IDLE, SWITCH, WATER, LOCKOUT} state_t;

    localparam logic MODE_DRIP     = 1'b0;
    localparam logic MODE_SPLINKER = 1'b1;

    localparam int DEF_DEAD_CYCLES      = 4;
    localparam int DEF_MIN_ON_CYCLES    = 16;
    localparam int DEF_LOCK_HOLD_CYCLES = 8;
    localparam int DEF_STABLE_CYCLES    = 3;

    function automatic int cnt_w(input int p);
        return $clog2(p < 2 ? 2 : p) + 1;
    endfunction

endpackage

// File: rtl/irrigation_mode_debounce.sv
// irrigation_mode_debounce: accepts a new mode only after STABLE_CYCLES consecutive equal samples
module irrigation_mode_debounce
    import irrigation_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic mode_in,
    output logic mode_eff
);

    localparam int W = cnt_w(STABLE_CYCLES);
    localparam logic [W-1:0] LAST = W'(STABLE_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_eff <= MODE_DRIP;
            cnt      <= '0;
        end else if (mode_in == mode_eff) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            mode_eff <= mode_in;
            cnt      <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/irrigation_valve_sequencer.sv
// irrigation_valve_sequencer: break-before-make valve driver with min on-time and safety lockout
// IRRIGATION_MODE_DEBOUNCE_EN filters splinker_mode_on before it reaches the FSM.
module irrigation_valve_sequencer
    import irrigation_pkg::*;
#(
    parameter int DEAD_CYCLES      = DEF_DEAD_CYCLES,
    parameter int MIN_ON_CYCLES    = DEF_MIN_ON_CYCLES,
    parameter int LOCK_HOLD_CYCLES = DEF_LOCK_HOLD_CYCLES,
    parameter int STABLE_CYCLES    = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic irrigate_req,
    input  logic splinker_mode_on,
    input  logic water_critical,
    input  logic sensor_fault,
    output logic splinker_valve,
    output logic dripper_valve,
    output logic active_mode,
    output logic lockout
);

    localparam int DW = cnt_w(DEAD_CYCLES);
    localparam int OW = cnt_w(MIN_ON_CYCLES);
    localparam int CW = cnt_w(LOCK_HOLD_CYCLES);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);
    localparam logic [OW-1:0] ON_MAX     = OW'(MIN_ON_CYCLES);
    localparam logic [CW-1:0] CLEAN_LAST = CW'(LOCK_HOLD_CYCLES - 1);

    if (DEAD_CYCLES < 1 || MIN_ON_CYCLES < 1 || LOCK_HOLD_CYCLES < 1 || STABLE_CYCLES < 1) begin : g_bad_param
        $error("irrigation_valve_sequencer: cycle parameters must be >= 1");
    end

    logic mode_eff;

`ifdef IRRIGATION_MODE_DEBOUNCE_EN
    irrigation_mode_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_mode_debounce (
        .clk      (clk),
        .reset    (reset),
        .mode_in  (splinker_mode_on),
        .mode_eff (mode_eff)
    );
`else
    assign mode_eff = splinker_mode_on;
`endif

    state_t          state, state_n;
    logic            target, target_n;
    logic [DW-1:0]   dead_cnt, dead_n;
    logic [OW-1:0]   on_cnt, on_n;
    logic [CW-1:0]   clean_cnt, clean_n;
    logic            lock;

    assign lock = water_critical | sensor_fault;

    always_comb begin
        state_n  = state;
        target_n = target;
        dead_n   = dead_cnt;
        on_n     = on_cnt;
        clean_n  = clean_cnt;
        if (lock) begin
            state_n = LOCKOUT;
            clean_n = '0;
        end else begin
            case (state)
                IDLE: if (irrigate_req) begin
                    state_n  = SWITCH;
                    target_n = mode_eff;
                    dead_n   = '0;
                end
                SWITCH: if (!irrigate_req) begin
                    state_n = IDLE;
                end else if (dead_cnt == DEAD_LAST) begin
                    state_n = WATER;
                    on_n    = '0;
                end else begin
                    dead_n = dead_cnt + DW'(1);
                end
                WATER: begin
                    on_n = (on_cnt == ON_MAX) ? on_cnt : on_cnt + OW'(1);
                    // stop wins over a simultaneous mode change
                    if (on_cnt == ON_MAX && !irrigate_req) begin
                        state_n = IDLE;
                    end else if (on_cnt == ON_MAX && mode_eff != target) begin
                        state_n  = SWITCH;
                        target_n = mode_eff;
                        dead_n   = '0;
                    end
                end
                LOCKOUT: if (clean_cnt == CLEAN_LAST) begin
                    state_n = IDLE;
                    clean_n = '0;
                end else begin
                    clean_n = clean_cnt + CW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            target         <= MODE_DRIP;
            dead_cnt       <= '0;
            on_cnt         <= '0;
            clean_cnt      <= '0;
            splinker_valve <= 1'b0;
            dripper_valve  <= 1'b0;
            active_mode    <= 1'b0;
            lockout        <= 1'b0;
        end else begin
            state          <= state_n;
            target         <= target_n;
            dead_cnt       <= dead_n;
            on_cnt         <= on_n;
            clean_cnt      <= clean_n;
            splinker_valve <= state_n == WATER && target_n == MODE_SPLINKER;
            dripper_valve  <= state_n == WATER && target_n == MODE_DRIP;
            active_mode    <= (state_n == SWITCH || state_n == WATER) && target_n == MODE_SPLINKER;
            lockout        <= state_n == LOCKOUT;
        end
    end

endmodule

// File: doc/irrigation_valve_sequencer.md
Name: irrigation_valve_sequencer

Overview:
- Consumes the sprinkler/drip mode decision from the irrigation selector and drives the two physical valves.
- Enforces a break-before-make dead time between valves and a minimum on-time per watering burst.
- Forces both valves closed in a safety lockout on critical water level or supply-sensor fault.
- Sits between the selector and the valve driver pins, under the irrigation controller.

Parameters:
- DEAD_CYCLES, 4: cycles both valves stay closed before any valve opens (legal range 1 or more).
- MIN_ON_CYCLES, 16: minimum cycles a valve stays open before a stop or mode change is honoured (legal range 1 or more).
- LOCK_HOLD_CYCLES, 8: consecutive clean cycles required to leave lockout (legal range 1 or more).
- STABLE_CYCLES, 3: consecutive equal samples needed to accept a mode change. Used only with IRRIGATION_MODE_DEBOUNCE_EN.

Ports:
- clk, input, 1: the single clock.
- reset, input, 1: asynchronous, active-high.
- irrigate_req, input, 1: controller requests watering.
- splinker_mode_on, input, 1: 1 selects sprinkler, 0 selects dripper (selector output).
- water_critical, input, 1: supply level critical.
- sensor_fault, input, 1: supply sensor fault.
- splinker_valve, output, 1: sprinkler valve open.
- dripper_valve, output, 1: dripper valve open.
- active_mode, output, 1: mode of the open or pending valve (1 = sprinkler).
- lockout, output, 1: safety lockout active.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is high, all outputs are 0, state is IDLE and all counters are 0.
- All outputs are registered. Output latency is 1 cycle from the sampled input.
- Invariant: splinker_valve and dripper_valve are never both 1.
- lock = water_critical | sensor_fault.
- Lock has priority over everything, in any state:
  - When lock is sampled 1, the next state is LOCKOUT.
  - Both valves are 0 and lockout is 1 on the next edge.
- mode_eff = splinker_mode_on (or the debounced value when the feature is enabled).

State machine:
- IDLE:
  - Valves 0.
  - If irrigate_req=1 and lock=0: latch target=mode_eff, go to SWITCH, clear dead_cnt.
- SWITCH:
  - Valves 0; active_mode = target.
  - dead_cnt increments each cycle.
  - When dead_cnt reaches DEAD_CYCLES-1: go to WATER, open the target valve, clear on_cnt.
  - Total closed time is exactly DEAD_CYCLES cycles.
  - irrigate_req dropping during SWITCH returns to IDLE next cycle.
- WATER:
  - The target valve is 1. on_cnt increments and saturates at MIN_ON_CYCLES.
  - While on_cnt < MIN_ON_CYCLES: irrigate_req and mode_eff are ignored.
  - Once on_cnt = MIN_ON_CYCLES:
    - irrigate_req=0: go to IDLE and close the valve. Stop takes priority over a mode change in the same cycle.
    - mode_eff != target: latch the new target, go to SWITCH and close the valve.
- LOCKOUT:
  - Valves 0; lockout=1; clean_cnt counts consecutive cycles with lock=0.
  - Any lock=1 clears clean_cnt.
  - When clean_cnt reaches LOCK_HOLD_CYCLES-1: go to IDLE, lockout=0.
  - Watering then restarts only through SWITCH, so a full dead time is applied.
- Counters:
  - Each counter is $clog2(max(param,2))+1 bits wide, unsigned.
  - No counter wraps; each is held or saturated at its terminal value.
- Reset mid-operation: valves close asynchronously and the FSM restarts in IDLE with no dead-time carry-over.

Optional Feature:
- Macro: IRRIGATION_MODE_DEBOUNCE_EN.
- Defined:
  - splinker_mode_on is filtered.
  - mode_eff changes only after STABLE_CYCLES consecutive samples equal to the new value.
  - This adds STABLE_CYCLES cycles of latency to mode changes.
  - At reset, mode_eff=0 and the filter count is 0.
- Undefined: mode_eff = splinker_mode_on directly, with zero added latency and no extra flops.

Decomposition:
- irrigation_pkg holds:
  - state typedef (IDLE, SWITCH, WATER, LOCKOUT);
  - mode constants MODE_DRIP=0 and MODE_SPLINKER=1;
  - default parameter constants.
- One sub-module: irrigation_mode_debounce. It is instantiated only under IRRIGATION_MODE_DEBOUNCE_EN.

Test Plan:
- Reset then irrigate_req=1, mode=1 → both valves 0 for 4 cycles, then splinker_valve=1 with active_mode=1.
- Watering in mode 1, drop irrigate_req at on_cnt=5 → valve stays open until 16 on-cycles are complete, then closes. IDLE follows.
- Watering in mode 0 past min-on, switch mode to 1 → dripper closes, 4 cycles with both valves 0, then sprinkler opens. No overlap cycle.
- water_critical pulse of 1 cycle mid-WATER → valves 0 and lockout=1 next cycle. Exactly 8 clean cycles later lockout=0; with irrigate_req still 1, a fresh 4-cycle dead time precedes the valve opening.
- Lock glitches during LOCKOUT at clean_cnt=6 → clean_cnt restarts; lockout extends accordingly.
- With IRRIGATION_MODE_DEBOUNCE_EN: a 2-cycle glitch on splinker_mode_on during WATER is ignored. A 3-cycle stable change causes a switch.
